// File: rtl/sram_arbiter_pkg.sv
// Shared types and constants for the two-port SRAM arbiter.
package sram_arbiter_pkg;

   localparam int unsigned WORD_SIZE = 8;
   localparam int unsigned ADDR_SIZE = 8;

   localparam logic PORT0 = 1'b0;
   localparam logic PORT1 = 1'b1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_OWN0 = 2'd1,
      S_OWN1 = 2'd2
   } state_t;

endpackage

// File: rtl/sram_arb_pick.sv
// Combinational round-robin selector: decides who owns the SRAM after the next edge.
module sram_arb_pick
   import sram_arbiter_pkg::*;
(
   input  logic   req_0,
   input  logic   req_1,
   input  logic   prio,
   input  state_t owner,
   input  logic   rel,
   input  logic   regrant,
   output state_t next_owner
);

   always_comb begin
      next_owner = owner;
      case (owner)
         S_IDLE: begin
            if (req_0 && req_1) begin
               next_owner = (prio == PORT1) ? S_OWN1 : S_OWN0;
            end else if (req_0) begin
               next_owner = S_OWN0;
            end else if (req_1) begin
               next_owner = S_OWN1;
            end else begin
               next_owner = S_IDLE;
            end
         end
         S_OWN0: begin
            if (rel) begin
               if (req_1) begin
                  next_owner = S_OWN1;
               end else if (regrant) begin
                  next_owner = S_OWN0;
               end else begin
                  next_owner = S_IDLE;
               end
            end
         end
         S_OWN1: begin
            if (rel) begin
               if (req_0) begin
                  next_owner = S_OWN0;
               end else if (regrant) begin
                  next_owner = S_OWN1;
               end else begin
                  next_owner = S_IDLE;
               end
            end
         end
         default: next_owner = S_IDLE;
      endcase
   end

endmodule

// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM between a CPU port and a DMA port.
module sram_arbiter
   import sram_arbiter_pkg::*;
#(
   parameter int unsigned word_size = WORD_SIZE,
   parameter int unsigned addr_size = ADDR_SIZE,
   parameter int unsigned max_burst = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req_0,
   input  logic [addr_size-1:0] addr_0,
   input  logic [word_size-1:0] wdata_0,
   input  logic                 write_0,
   input  logic                 last_0,
   output logic                 gnt_0,
   output logic [word_size-1:0] rdata_0,
   input  logic                 req_1,
   input  logic [addr_size-1:0] addr_1,
   input  logic [word_size-1:0] wdata_1,
   input  logic                 write_1,
   input  logic                 last_1,
   output logic                 gnt_1,
   output logic [word_size-1:0] rdata_1,
   output logic [addr_size-1:0] mem_address,
   output logic [word_size-1:0] mem_data_in,
   output logic                 mem_write,
   input  logic [word_size-1:0] mem_data_out,
   output logic                 busy
);

   localparam int unsigned BEAT_W = (max_burst > 1) ? $clog2(max_burst) : 1;

   state_t            state_q, state_d;
   logic              prio_q, prio_d;
   logic [BEAT_W-1:0] beat_q, beat_d;

   logic acc_0, acc_1;
   logic beat_last;
   logic own_req, own_last;
   logic rel, regrant;

   assign gnt_0 = (state_q == S_OWN0);
   assign gnt_1 = (state_q == S_OWN1);
   assign busy  = gnt_0 | gnt_1;
   assign acc_0 = gnt_0 & req_0;
   assign acc_1 = gnt_1 & req_1;

   assign beat_last = (beat_q == BEAT_W'(max_burst - 1));
   assign own_req   = (gnt_0 & req_0) | (gnt_1 & req_1);
   assign own_last  = (gnt_0 & last_0) | (gnt_1 & last_1);
   // Dropping req, a final beat, or exhausting the burst all release the grant.
   assign rel       = busy & (~own_req | own_last | beat_last);
   assign regrant   = own_req & ~own_last;

   sram_arb_pick u_pick (
      .req_0      (req_0),
      .req_1      (req_1),
      .prio       (prio_q),
      .owner      (state_q),
      .rel        (rel),
      .regrant    (regrant),
      .next_owner (state_d)
   );

   always_comb begin
      prio_d = prio_q;
      if (rel) begin
         prio_d = gnt_0 ? PORT1 : PORT0;
      end
      beat_d = '0;
      if (busy && !rel) begin
         beat_d = beat_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         prio_q  <= PORT0;
         beat_q  <= '0;
      end else begin
         state_q <= state_d;
         prio_q  <= prio_d;
         beat_q  <= beat_d;
      end
   end

   always_comb begin
      mem_address = '0;
      mem_data_in = '0;
      mem_write   = 1'b0;
      if (acc_0) begin
         mem_address = addr_0;
         mem_data_in = wdata_0;
         mem_write   = write_0;
      end else if (acc_1) begin
         mem_address = addr_1;
         mem_data_in = wdata_1;
         mem_write   = write_1;
      end
   end

   assign rdata_0 = acc_0 ? mem_data_out : '0;
   assign rdata_1 = acc_1 ? mem_data_out : '0;

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: directed scenarios plus a randomized run against a model.
module tb_sram_arbiter;

   localparam int MAX = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       req_0 = 0, write_0 = 0, last_0 = 0;
   logic       req_1 = 0, write_1 = 0, last_1 = 0;
   logic [7:0] addr_0 = 0, wdata_0 = 0, addr_1 = 0, wdata_1 = 0;
   logic       gnt_0, gnt_1, mem_write, busy;
   logic [7:0] rdata_0, rdata_1, mem_address, mem_data_in, mem_data_out;

   logic [7:0] tb_mem  [256];
   logic [7:0] ref_mem [256];

   int n_vec = 0;
   int n_bad = 0;

   int m_owner, m_prio, m_cnt;

   always #5 clk = ~clk;

   assign mem_data_out = tb_mem[mem_address];
   always @(posedge clk) if (mem_write) tb_mem[mem_address] = mem_data_in;

   sram_arbiter #(.word_size(8), .addr_size(8), .max_burst(MAX)) dut (
      .clk(clk), .rst(rst),
      .req_0(req_0), .addr_0(addr_0), .wdata_0(wdata_0), .write_0(write_0), .last_0(last_0),
      .gnt_0(gnt_0), .rdata_0(rdata_0),
      .req_1(req_1), .addr_1(addr_1), .wdata_1(wdata_1), .write_1(write_1), .last_1(last_1),
      .gnt_1(gnt_1), .rdata_1(rdata_1),
      .mem_address(mem_address), .mem_data_in(mem_data_in), .mem_write(mem_write),
      .mem_data_out(mem_data_out), .busy(busy)
   );

   task automatic clear_inputs();
      req_0 = 0; write_0 = 0; last_0 = 0; addr_0 = 0; wdata_0 = 0;
      req_1 = 0; write_1 = 0; last_1 = 0; addr_1 = 0; wdata_1 = 0;
   endtask

   task automatic do_reset();
      clear_inputs();
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      m_owner = -1; m_prio = 0; m_cnt = 0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      req_0 = 1; req_1 = 1; write_0 = 1; addr_0 = 8'h44; wdata_0 = 8'h55;
      @(negedge clk); @(negedge clk);
      #1;
      n_vec++; if ({gnt_0, gnt_1, busy} !== 3'b000) begin
         n_bad++; $display("FAIL rst_gnt got %b want 000", {gnt_0, gnt_1, busy}); end
      n_vec++; if (mem_write !== 1'b0) begin
         n_bad++; $display("FAIL rst_wr got %b want 0", mem_write); end
      n_vec++; if ({mem_address, mem_data_in} !== 16'h0000) begin
         n_bad++; $display("FAIL rst_bus got %h want 0000", {mem_address, mem_data_in}); end
      do_reset();
   endtask

   task automatic test_single_read();
      tb_mem[8'h10] = 8'hA5;
      req_0 = 1; addr_0 = 8'h10; write_0 = 0;
      #1;
      n_vec++; if (gnt_0 !== 1'b0) begin
         n_bad++; $display("FAIL rd_latency got %b want 0", gnt_0); end
      @(negedge clk); #1;
      n_vec++; if ({gnt_0, gnt_1, mem_write} !== 3'b100) begin
         n_bad++; $display("FAIL rd_gnt got %b want 100", {gnt_0, gnt_1, mem_write}); end
      n_vec++; if (rdata_0 !== 8'hA5) begin
         n_bad++; $display("FAIL rd_data got %h want a5", rdata_0); end
      n_vec++; if (mem_address !== 8'h10) begin
         n_bad++; $display("FAIL rd_addr got %h want 10", mem_address); end
      req_0 = 0;
      @(negedge clk); #1;
      n_vec++; if (gnt_0 !== 1'b0) begin
         n_bad++; $display("FAIL rd_release got %b want 0", gnt_0); end
   endtask

   task automatic test_round_robin();
      logic [1:0] want;
      do_reset();
      req_0 = 1; req_1 = 1; addr_0 = 8'h01; addr_1 = 8'h02;
      @(negedge clk);
      for (int k = 0; k < 3 * MAX; k++) begin
         want = ((k / MAX) % 2 == 0) ? 2'b10 : 2'b01;
         #1;
         n_vec++; if ({gnt_0, gnt_1} !== want) begin
            n_bad++; $display("FAIL rr_cycle%0d got %b want %b", k, {gnt_0, gnt_1}, want); end
         @(negedge clk);
      end
      clear_inputs();
      @(negedge clk);
   endtask

   task automatic test_write_last();
      do_reset();
      tb_mem[8'h20] = 8'h00;
      req_1 = 1; addr_1 = 8'h20; wdata_1 = 8'h3C; write_1 = 1; last_1 = 1;
      @(negedge clk); #1;
      n_vec++; if ({gnt_1, mem_write, mem_address, mem_data_in} !== {2'b11, 8'h20, 8'h3C}) begin
         n_bad++; $display("FAIL wl_bus got %b %b %h %h want 1 1 20 3c",
                           gnt_1, mem_write, mem_address, mem_data_in); end
      @(negedge clk);
      clear_inputs();
      #1;
      n_vec++; if (gnt_1 !== 1'b0) begin
         n_bad++; $display("FAIL wl_idle got %b want 0", gnt_1); end
      n_vec++; if (tb_mem[8'h20] !== 8'h3C) begin
         n_bad++; $display("FAIL wl_mem got %h want 3c", tb_mem[8'h20]); end
      req_0 = 1; addr_0 = 8'h20;
      @(negedge clk); #1;
      n_vec++; if (rdata_0 !== 8'h3C) begin
         n_bad++; $display("FAIL wl_readback got %h want 3c", rdata_0); end
      clear_inputs();
      @(negedge clk);
   endtask

   task automatic test_drop_req();
      do_reset();
      tb_mem[8'h41] = 8'h11;
      req_0 = 1; write_0 = 1; addr_0 = 8'h40; wdata_0 = 8'h77;
      @(negedge clk); @(negedge clk); @(negedge clk);
      req_0 = 0; addr_0 = 8'h41; wdata_0 = 8'h99;
      #1;
      n_vec++; if ({gnt_0, mem_write, mem_address} !== {2'b10, 8'h00}) begin
         n_bad++; $display("FAIL drop_bus got %b %b %h want 1 0 00", gnt_0, mem_write, mem_address); end
      @(negedge clk); #1;
      n_vec++; if (gnt_0 !== 1'b0 || tb_mem[8'h41] !== 8'h11) begin
         n_bad++; $display("FAIL drop_nowrite got %b %h want 0 11", gnt_0, tb_mem[8'h41]); end
      n_vec++; if (tb_mem[8'h40] !== 8'h77) begin
         n_bad++; $display("FAIL drop_beats got %h want 77", tb_mem[8'h40]); end
      write_0 = 0; req_0 = 1; req_1 = 1;
      @(negedge clk); #1;
      n_vec++; if ({gnt_0, gnt_1} !== 2'b01) begin
         n_bad++; $display("FAIL drop_prio got %b want 01", {gnt_0, gnt_1}); end
      clear_inputs();
      @(negedge clk);
   endtask

   task automatic test_nonowner_write();
      do_reset();
      tb_mem[8'h30] = 8'h12;
      req_1 = 1; addr_1 = 8'h05;
      @(negedge clk);
      req_0 = 1; write_0 = 1; addr_0 = 8'h30; wdata_0 = 8'hEE;
      for (int k = 0; k < MAX; k++) begin
         #1;
         n_vec++; if ({gnt_0, gnt_1, mem_write} !== 3'b010) begin
            n_bad++; $display("FAIL nw_cycle%0d got %b want 010", k, {gnt_0, gnt_1, mem_write}); end
         @(negedge clk);
      end
      write_0 = 0;
      #1;
      n_vec++; if (gnt_0 !== 1'b1 || tb_mem[8'h30] !== 8'h12) begin
         n_bad++; $display("FAIL nw_mem got %b %h want 1 12", gnt_0, tb_mem[8'h30]); end
      clear_inputs();
      @(negedge clk); @(negedge clk);
   endtask

   task automatic test_async_reset();
      do_reset();
      req_0 = 1; write_0 = 1; addr_0 = 8'h50; wdata_0 = 8'h01;
      @(negedge clk); #1;
      n_vec++; if (mem_write !== 1'b1) begin
         n_bad++; $display("FAIL ar_pre got %b want 1", mem_write); end
      #2 rst = 1'b0;
      #1;
      n_vec++; if ({gnt_0, gnt_1, mem_write, busy} !== 4'b0000) begin
         n_bad++; $display("FAIL ar_drop got %b want 0000", {gnt_0, gnt_1, mem_write, busy}); end
      @(negedge clk);
      rst = 1'b1;
      write_0 = 0; req_1 = 1;
      #1;
      n_vec++; if (busy !== 1'b0) begin
         n_bad++; $display("FAIL ar_idle got %b want 0", busy); end
      @(negedge clk); #1;
      n_vec++; if ({gnt_0, gnt_1} !== 2'b10) begin
         n_bad++; $display("FAIL ar_prio got %b want 10", {gnt_0, gnt_1}); end
      clear_inputs();
      @(negedge clk);
   endtask

   task automatic test_random();
      logic       a0, a1, rq, ls, orq;
      logic [7:0] e_addr, e_din, e_rd0, e_rd1;
      logic       e_wr;
      do_reset();
      for (int i = 0; i < 256; i++) ref_mem[i] = tb_mem[i];
      for (int i = 0; i < 400; i++) begin
         req_0 = ($urandom_range(3) != 0); req_1 = ($urandom_range(3) != 0);
         write_0 = $urandom_range(1); write_1 = $urandom_range(1);
         last_0 = ($urandom_range(3) == 0); last_1 = ($urandom_range(3) == 0);
         addr_0 = 8'($urandom); addr_1 = 8'($urandom);
         wdata_0 = 8'($urandom); wdata_1 = 8'($urandom);
         #1;
         a0 = (m_owner == 0) && req_0;
         a1 = (m_owner == 1) && req_1;
         e_addr = a0 ? addr_0 : (a1 ? addr_1 : 8'h00);
         e_din  = a0 ? wdata_0 : (a1 ? wdata_1 : 8'h00);
         e_wr   = a0 ? write_0 : (a1 ? write_1 : 1'b0);
         e_rd0  = a0 ? ref_mem[addr_0] : 8'h00;
         e_rd1  = a1 ? ref_mem[addr_1] : 8'h00;
         n_vec++; if ({gnt_0, gnt_1, busy} !== {m_owner == 0, m_owner == 1, m_owner >= 0}) begin
            n_bad++; $display("FAIL rnd%0d_gnt got %b want owner %0d", i, {gnt_0, gnt_1, busy}, m_owner); end
         n_vec++; if ({mem_write, mem_address, mem_data_in} !== {e_wr, e_addr, e_din}) begin
            n_bad++; $display("FAIL rnd%0d_bus got %b %h %h want %b %h %h", i,
                              mem_write, mem_address, mem_data_in, e_wr, e_addr, e_din); end
         n_vec++; if ({rdata_0, rdata_1} !== {e_rd0, e_rd1}) begin
            n_bad++; $display("FAIL rnd%0d_rdata got %h %h want %h %h", i,
                              rdata_0, rdata_1, e_rd0, e_rd1); end
         @(posedge clk);
         if (m_owner < 0) begin
            if (req_0 && req_1) m_owner = m_prio;
            else if (req_0) m_owner = 0;
            else if (req_1) m_owner = 1;
            m_cnt = 0;
         end else begin
            rq  = (m_owner == 0) ? req_0 : req_1;
            ls  = (m_owner == 0) ? last_0 : last_1;
            orq = (m_owner == 0) ? req_1 : req_0;
            if (a0 && write_0) ref_mem[addr_0] = wdata_0;
            if (a1 && write_1) ref_mem[addr_1] = wdata_1;
            if (rq && !ls && m_cnt < MAX - 1) begin
               m_cnt++;
            end else begin
               m_prio = 1 - m_owner;
               if (orq) m_owner = 1 - m_owner;
               else if (!(rq && !ls)) m_owner = -1;
               m_cnt = 0;
            end
         end
         @(negedge clk);
      end
      clear_inputs();
   endtask

   initial begin
      for (int i = 0; i < 256; i++) tb_mem[i] = 8'($urandom);
      test_reset();
      test_single_read();
      test_round_robin();
      test_write_last();
      test_drop_req();
      test_nonowner_write();
      test_async_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Shares the single-port 8-bit SRAM (async read, write on posedge clk) between two requesters: port 0 (processor fetch/load/store path) and port 1 (DMA/program-loader path).
- Round-robin arbitration with registered grants, bounded burst lock and a per-cycle access mux.
- Sits between the requesters and the SRAM address, data-in and write pins.

Parameters:
word_size, 8, data width
addr_size, 8, address width
max_burst, 4, max access cycles per grant (>=1)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active low
req_0  in  1  port 0 requests / holds memory
addr_0  in  addr_size  port 0 address
wdata_0  in  word_size  port 0 write data
write_0  in  1  port 0 write strobe (1=write, 0=read)
last_0  in  1  port 0 final access of this burst
gnt_0  out  1  port 0 owns memory this cycle
rdata_0  out  word_size  read data to port 0
req_1, addr_1, wdata_1, write_1, last_1, gnt_1, rdata_1  same for port 1
mem_address  out  addr_size  SRAM address
mem_data_in  out  word_size  SRAM write data
mem_write  out  1  SRAM write enable
mem_data_out  in  word_size  SRAM async read data
busy  out  1  either grant active

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous active-low. While rst=0: state=S_IDLE, prio=0, beat=0, gnt_0=gnt_1=0, mem_write=0, mem_address=0, mem_data_in=0, busy=0.
- Reset mid-burst: grants and mem_write drop immediately with no clock edge needed. Any partial burst is abandoned.
- States: S_IDLE, S_OWN0, S_OWN1. The grants are state-decoded (gnt_0 = state==S_OWN0), so they are registered.
- Grant latency: a request at edge N is granted from edge N+1. There is no combinational req-to-gnt path.
- Access rule: an access occurs in any cycle with gnt_x=1 and req_x=1.
  - mem_address=addr_x, mem_data_in=wdata_x, mem_write=write_x.
  - rdata_x=mem_data_out combinationally in the same cycle.
  - Non-owner rdata=0.
- No access (S_IDLE, or owner with req_x=0): mem_address=0, mem_data_in=0, mem_write=0.
- beat: counts accesses within the current grant. It clears on every grant change.
- Release condition for owner x at an edge, any one of:
  - req_x=0
  - access with last_x=1
  - access with beat==max_burst-1
- S_IDLE transitions:
  - Neither request: stay in S_IDLE.
  - One request: grant that port.
  - Both requests: grant port prio.
- S_OWNx transitions:
  - No release: stay in S_OWNx, beat+1.
  - Release and other req pending: go directly to S_OWNy with no idle bubble; beat=0.
  - Release, other idle, req_x=1 and last_x=0 (burst-limit case): regrant x; beat=0.
  - Otherwise: go to S_IDLE.
- prio: on every release from S_OWNx, prio := ~x. A continuously requesting port therefore cannot starve the other beyond max_burst cycles plus 1.
- Owner drops req mid-burst: no access that cycle, release at that edge, no write issued.
- Writes: happen only when gnt_x & req_x & write_x. A write issued by a non-owner is ignored, not queued.
- Address range: full range, no wrap-around handling. Addresses pass through unmodified.
- busy = gnt_0 | gnt_1.

Decomposition:
- Shared package: state codes (S_IDLE=0, S_OWN0=1, S_OWN1=2, 2-bit) and port index constants PORT0=0, PORT1=1.
- Reuse the existing opcode/word_size constants where word_size is referenced.
- One natural sub-module: sram_arb_pick. It is a combinational round-robin selector with inputs req_0, req_1, prio, current owner and release, and it outputs the next owner.
- The FSM, beat counter and output mux stay in sram_arbiter.

Test Plan:
- Reset, then only req_0=1 with addr_0=8'h10, write_0=0 (mem[10]=8'hA5) → gnt_0 rises one edge later; rdata_0=8'hA5 same cycle; gnt_1=0, mem_write=0.
- Both req asserted from S_IDLE, prio=0, max_burst=4, last=0 → gnt_0 for exactly 4 cycles, then gnt_1 on the next cycle with no bubble; after port 1's 4 beats, gnt_0 returns.
- Port 1 writes 8'h3C to 8'h20 with last_1=1 on its single access → mem[20]=8'h3C, then S_IDLE; a port 0 read of 8'h20 afterwards returns 8'h3C.
- Port 0 owns, drops req_0 after 2 beats while write_0=1 remains high → no write in the drop cycle (mem unchanged), release, prio=1.
- Port 0 asserts write_0=1 to 8'h30 while port 1 owns → mem[30] unchanged; gnt_0=0 until port 1 releases.
- rst pulled low mid-burst between edges → gnt_x, mem_write and busy go 0 immediately; after release of rst, state is S_IDLE and prio=0.
